song_reader: RTL and testbench

//  Playback engine for a recorded song held in the note/duration memory.

---
 rtl/song_reader_pkg.sv | 27 ++
 rtl/song_reader_tick_gen.sv | 40 ++++
 rtl/song_reader.sv | 193 +++++++++++++++++++
 tb/tb_song_reader.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/song_reader_pkg.sv
// song_reader_pkg
//   Shared constants for the song playback engine: FSM state codes, the
//   recorder top-level mode codes, default tick length and a small helper.
package song_reader_pkg;

  // Top-level recorder modes, used by the surrounding controller.
  localparam logic [1:0] MODE_IDLE   = 2'd0;
  localparam logic [1:0] MODE_RECORD = 2'd1;
  localparam logic [1:0] MODE_PLAY   = 2'd2;

  // Playback FSM state encodings.
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_LOAD  = 3'd2;
  localparam logic [2:0] ST_PLAY  = 3'd3;
  localparam logic [2:0] ST_GAP   = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  // 0.1 s at 100 MHz.
  localparam int TICK_CYCLES_DEF = 10_000_000;

  // Width of a counter that must hold values 0..n-1 (at least 1 bit).
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/song_reader_tick_gen.sv
// play_tick_gen
//   Duration prescaler: emits a one-cycle tick after every TICK_CYCLES
//   enabled cycles. clear restarts the count so the next tick lands exactly
//   TICK_CYCLES enabled cycles later.
// Ports:
//   clk   in  system clock
//   rst   in  asynchronous active-low reset
//   en    in  count enable (counter frozen when low)
//   clear in  synchronous restart of the prescaler
//   tick  out high in the last cycle of each TICK_CYCLES period
module play_tick_gen
  import song_reader_pkg::*;
#(
  parameter int TICK_CYCLES = TICK_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clear,
  output logic tick
);

  localparam int CW = cnt_width(TICK_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(TICK_CYCLES - 1);

  logic [CW-1:0] r_cnt;

  assign tick = en && !clear && (r_cnt == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= tick ? '0 : r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/song_reader.sv
// song_reader
//   Plays back a recorded song from the note/duration memory. Each entry is
//   fetched (one cycle of read latency), loaded, and held for len ticks;
//   sounding notes are followed by a forced silent gap. Playback ends on the
//   {0,0} end marker, after entry SONG_MAX-1, or on a stop pulse.
// Ports:
//   clk       in  system clock
//   rst       in  asynchronous active-low reset
//   en        in  global enable; low freezes every register
//   start     in  pulse, start playing from entry 0 (ignored unless IDLE)
//   stop      in  pulse, abort playback (wins over start)
//   mem_addr  out read address into the song memory
//   mem_note  in  note code at mem_addr, one cycle after the address
//   mem_len   in  duration in ticks, same timing as mem_note
//   music     out current music code, 0 = silence
//   playing   out high in every state except IDLE
//   done      out one-cycle pulse on natural end of song
module song_reader
  import song_reader_pkg::*;
#(
  parameter int TICK_CYCLES = TICK_CYCLES_DEF,
  parameter int GAP_CYCLES  = 1_000_000,
  parameter int SONG_MAX    = 100,
  parameter int ADDR_W      = 7,
  parameter int NOTE_W      = 5,
  parameter int LEN_W       = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              start,
  input  logic              stop,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [NOTE_W-1:0] mem_note,
  input  logic [LEN_W-1:0]  mem_len,
  output logic [NOTE_W-1:0] music,
  output logic              playing,
  output logic              done
);

  localparam int GW = cnt_width(GAP_CYCLES);
  localparam logic [GW-1:0]     GAP_LAST  = GW'(GAP_CYCLES - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(SONG_MAX - 1);

  logic [2:0]        r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [LEN_W-1:0]  r_len_q;
  logic [LEN_W-1:0]  r_len_cnt;
  logic [GW-1:0]     r_gap_cnt;
  logic [NOTE_W-1:0] r_music;
  logic              r_done;

  logic w_tick;
  logic w_tick_en;
  logic w_tick_clr;
  logic w_abort;
  logic w_end_marker;
  logic w_play_end;
  logic w_last_entry;
  logic w_take_gap;
  logic w_gap_end;

  // Prescaler only runs while a note is being held; LOAD restarts it so the
  // first tick of every note is a full TICK_CYCLES away.
  assign w_tick_en  = en && (r_state == ST_PLAY);
  assign w_tick_clr = en && (r_state == ST_LOAD);

  play_tick_gen #(
    .TICK_CYCLES(TICK_CYCLES)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (w_tick_en),
    .clear(w_tick_clr),
    .tick (w_tick)
  );

  assign w_abort      = stop && (r_state != ST_IDLE);
  assign w_end_marker = (mem_note == '0) && (mem_len == '0);
  assign w_play_end   = (r_state == ST_PLAY) && w_tick &&
                        (r_len_cnt == r_len_q - LEN_W'(1));
  assign w_last_entry = (r_addr == ADDR_LAST);
  // Rests already sound silent, so they never get a gap.
  assign w_take_gap   = (GAP_CYCLES > 0) && (r_music != '0);
  assign w_gap_end    = (r_state == ST_GAP) && (r_gap_cnt == GAP_LAST);

  // Sequencing FSM: state, address and duration counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_addr    <= '0;
      r_len_q   <= '0;
      r_len_cnt <= '0;
      r_gap_cnt <= '0;
    end else if (en) begin
      if (w_abort) begin
        r_state   <= ST_IDLE;
        r_addr    <= '0;
        r_len_cnt <= '0;
        r_gap_cnt <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (start && !stop) begin
              r_state <= ST_FETCH;
              r_addr  <= '0;
            end
          end
          ST_FETCH: r_state <= ST_LOAD;
          ST_LOAD: begin
            if (w_end_marker) begin
              r_state <= ST_DONE;
            end else begin
              // A zero length on a real note still plays one tick.
              r_len_q   <= (mem_len == '0) ? LEN_W'(1) : mem_len;
              r_len_cnt <= '0;
              r_state   <= ST_PLAY;
            end
          end
          ST_PLAY: begin
            if (w_play_end) begin
              r_len_cnt <= '0;
              if (w_last_entry) begin
                r_state <= ST_DONE;
              end else if (w_take_gap) begin
                r_gap_cnt <= '0;
                r_state   <= ST_GAP;
              end else begin
                r_addr  <= r_addr + ADDR_W'(1);
                r_state <= ST_FETCH;
              end
            end else if (w_tick) begin
              r_len_cnt <= r_len_cnt + LEN_W'(1);
            end
          end
          ST_GAP: begin
            if (w_gap_end) begin
              r_gap_cnt <= '0;
              r_addr    <= r_addr + ADDR_W'(1);
              r_state   <= ST_FETCH;
            end else begin
              r_gap_cnt <= r_gap_cnt + GW'(1);
            end
          end
          ST_DONE: r_state <= ST_IDLE;
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  // Output register. music is silenced on the same edge a note ends so its
  // duration is exact; done is high exactly during the DONE state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_music <= '0;
      r_done  <= 1'b0;
    end else if (en) begin
      r_done <= 1'b0;
      if (w_abort) begin
        r_music <= '0;
      end else begin
        case (r_state)
          ST_LOAD: begin
            if (w_end_marker) begin
              r_music <= '0;
              r_done  <= 1'b1;
            end else begin
              r_music <= mem_note;
            end
          end
          ST_PLAY: begin
            if (w_play_end && (w_last_entry || w_take_gap)) begin
              r_music <= '0;
            end
            if (w_play_end && w_last_entry) begin
              r_done <= 1'b1;
            end
          end
          ST_DONE: r_music <= '0;
          ST_IDLE: r_music <= '0;
          default: ;
        endcase
      end
    end
  end

  assign mem_addr = r_addr;
  assign music    = r_music;
  assign done     = r_done;
  assign playing  = (r_state != ST_IDLE);

endmodule

// File: tb/tb_song_reader.sv
// tb_song_reader
//   Self-checking bench for song_reader with TICK_CYCLES=4, GAP_CYCLES=2,
//   SONG_MAX=8. A timeline model expands the song memory into the expected
//   per-cycle {playing, done, music, mem_addr} sequence.
module tb_song_reader;

  localparam int TICK   = 4;
  localparam int GAP    = 2;
  localparam int SMAX   = 8;
  localparam int ADDR_W = 7;
  localparam int NOTE_W = 5;
  localparam int LEN_W  = 4;
  localparam int OBS_W  = 2 + NOTE_W + ADDR_W;

  logic              clk;
  logic              rst;
  logic              en;
  logic              start;
  logic              stop;
  logic [ADDR_W-1:0] mem_addr;
  logic [NOTE_W-1:0] mem_note;
  logic [LEN_W-1:0]  mem_len;
  logic [NOTE_W-1:0] music;
  logic              playing;
  logic              done;

  logic [NOTE_W-1:0] tb_note [0:(1<<ADDR_W)-1];
  logic [LEN_W-1:0]  tb_len  [0:(1<<ADDR_W)-1];

  logic [OBS_W-1:0] exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  song_reader #(
    .TICK_CYCLES(TICK),
    .GAP_CYCLES (GAP),
    .SONG_MAX   (SMAX),
    .ADDR_W     (ADDR_W),
    .NOTE_W     (NOTE_W),
    .LEN_W      (LEN_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .start   (start),
    .stop    (stop),
    .mem_addr(mem_addr),
    .mem_note(mem_note),
    .mem_len (mem_len),
    .music   (music),
    .playing (playing),
    .done    (done)
  );

  // ---------------- clock / reset / memory ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read song memory: data for an address appears one clk later.
  always @(posedge clk) begin
    mem_note <= tb_note[mem_addr];
    mem_len  <= tb_len[mem_addr];
  end

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [OBS_W-1:0] obs();
    return {playing, done, music, mem_addr};
  endfunction

  function automatic logic [OBS_W-1:0] pack(input logic p, input logic d,
                                            input logic [NOTE_W-1:0] m,
                                            input int a);
    return {p, d, m, ADDR_W'(a)};
  endfunction

  // ---------------- reference model ----------------
  // Expands the memory into the expected sample after every enabled edge,
  // starting with the edge that samples start.
  task automatic build_model();
    logic [NOTE_W-1:0] prev;
    int ticks;
    exp_q.delete();
    prev = '0;
    for (int i = 0; i < SMAX; i++) begin
      exp_q.push_back(pack(1'b1, 1'b0, prev, i));   // fetch
      exp_q.push_back(pack(1'b1, 1'b0, prev, i));   // load
      if (tb_note[i] == 0 && tb_len[i] == 0) begin
        exp_q.push_back(pack(1'b1, 1'b1, '0, i));
        exp_q.push_back(pack(1'b0, 1'b0, '0, i));
        return;
      end
      ticks = (tb_len[i] == 0) ? 1 : int'(tb_len[i]);
      for (int c = 0; c < ticks * TICK; c++)
        exp_q.push_back(pack(1'b1, 1'b0, tb_note[i], i));
      prev = tb_note[i];
      if (i == SMAX - 1) begin
        exp_q.push_back(pack(1'b1, 1'b1, '0, i));
        exp_q.push_back(pack(1'b0, 1'b0, '0, i));
        return;
      end
      if (prev != 0) begin
        for (int c = 0; c < GAP; c++)
          exp_q.push_back(pack(1'b1, 1'b0, '0, i));
        prev = '0;
      end
    end
  endtask

  // ---------------- drivers ----------------
  task automatic clear_mem();
    for (int i = 0; i < (1 << ADDR_W); i++) begin
      tb_note[i] = '0;
      tb_len[i]  = '0;
    end
  endtask

  task automatic set_entry(input int i, input int n, input int l);
    tb_note[i] = NOTE_W'(n);
    tb_len[i]  = LEN_W'(l);
  endtask

  // Random song of n entries (no end marker inside), optional end marker.
  task automatic rand_song(input int n, input bit rests);
    clear_mem();
    for (int i = 0; i < n; i++) begin
      int nt;
      int ln;
      nt = (rests && $urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 31);
      ln = $urandom_range(0, 3);
      if (nt == 0 && ln == 0) ln = 1;
      set_entry(i, nt, ln);
    end
  endtask

  // en_mode: 0 always on, 1 random, 2 low for samples 5..14.
  // stop_at >= 0 aborts playback after that many samples.
  task automatic run_song(input int en_mode, input int stop_at,
                          output int n_first);
    logic [OBS_W-1:0] cur;
    logic [NOTE_W-1:0] first;
    logic en_used;
    int cyc;
    build_model();
    first   = tb_note[0];
    n_first = 0;
    cur     = '0;
    cyc     = 0;
    @(negedge clk);
    start = 1'b1;
    en    = 1'b1;
    while (exp_q.size() > 0 && cyc < 4000) begin
      en_used = en;
      @(negedge clk);
      start = 1'b0;
      stop  = 1'b0;
      if (en_used) cur = exp_q.pop_front();
      check_eq("trace", 32'(obs()), 32'(cur));
      if (music == first) n_first++;
      cyc++;
      if (cyc == stop_at) begin
        en   = 1'b1;
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check_eq("stop_outputs", 32'(obs()), 32'(0));
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          check_eq("stop_no_done", {30'd0, done, playing}, 32'd0);
        end
        exp_q.delete();
      end else begin
        case (en_mode)
          1:       en = ($urandom_range(0, 3) != 0);
          2:       en = !(cyc >= 5 && cyc < 15);
          default: en = 1'b1;
        endcase
      end
    end
    check_eq("budget", 32'(exp_q.size()), 32'd0);
    en = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // ---------------- main sequence ----------------
  int n_first;

  initial begin
    rst   = 1'b0;
    en    = 1'b1;
    start = 1'b0;
    stop  = 1'b0;
    clear_mem();
    repeat (3) @(negedge clk);
    check_eq("reset_outputs", {18'd0, obs()}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check_eq("idle_after_reset", {18'd0, obs()}, 32'd0);

    // 1: two notes then end marker.
    clear_mem();
    set_entry(0, 5, 2);
    set_entry(1, 9, 1);
    run_song(0, -1, n_first);
    check_eq("note5_len", 32'(n_first), 32'd8);

    // 2: rest between notes, no extra gap.
    clear_mem();
    set_entry(0, 5, 1);
    set_entry(1, 0, 3);
    set_entry(2, 7, 1);
    run_song(0, -1, n_first);

    // 3: stop mid-note.
    clear_mem();
    set_entry(0, 6, 3);
    set_entry(1, 2, 1);
    run_song(0, 6, n_first);

    // 4: all entries nonzero, playback ends after the last entry.
    rand_song(SMAX, 1'b0);
    run_song(0, -1, n_first);

    // 5: en low for 10 clks mid-note stretches the note to 18 clks.
    clear_mem();
    set_entry(0, 5, 2);
    run_song(2, -1, n_first);
    check_eq("en_freeze_len", 32'(n_first), 32'd18);

    // start and stop together from IDLE: stays IDLE.
    @(negedge clk);
    start = 1'b1;
    stop  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    check_eq("start_stop_idle", {31'd0, playing}, 32'd0);
    @(negedge clk);
    check_eq("start_stop_idle2", {30'd0, playing, done}, 32'd0);

    // 6: zero-length note plays one tick; async reset mid-gap.
    clear_mem();
    set_entry(0, 3, 0);
    set_entry(1, 4, 1);
    run_song(0, -1, n_first);
    check_eq("len0_one_tick", 32'(n_first), 32'(TICK));

    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    // Sample 14: first gap cycle after entry 1.
    check_eq("in_gap", 32'(obs()), 32'(pack(1'b1, 1'b0, '0, 1)));
    #2 rst = 1'b0;
    #1 check_eq("async_reset", {18'd0, obs()}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Randomized songs with rests, with and without random enable.
    for (int r = 0; r < 12; r++) begin
      rand_song($urandom_range(1, SMAX), 1'b1);
      if ($urandom_range(0, 1) == 1 && r < 11) begin
        int k;
        k = $urandom_range(1, SMAX);
        for (int i = k; i < SMAX; i++) set_entry(i, 0, 0);
      end
      run_song(r % 2, -1, n_first);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
